// File: rtl/operand_fetch_unit_pkg.sv
// Shared definitions for the operand fetch unit: data-RAM geometry, tag width
// and the packed payloads carried on the fetch interface.
package operand_fetch_unit_pkg;

    localparam int unsigned DATA_ROW_WIDTH     = 32;
    localparam int unsigned DATA_ADDRESS_WIDTH = 6;
    localparam int unsigned OFU_TAG_WIDTH      = 8;

    typedef logic [DATA_ROW_WIDTH-1:0]     ofu_data_t;
    typedef logic [DATA_ADDRESS_WIDTH-1:0] ofu_addr_t;
    typedef logic [OFU_TAG_WIDTH-1:0]      ofu_tag_t;

    // Issue request: two source addresses plus an opaque tag
    typedef struct packed {
        ofu_addr_t addr0;
        ofu_addr_t addr1;
        ofu_tag_t  tag;
    } ofu_req_t;

    // Operand pair handed to execute
    typedef struct packed {
        ofu_data_t data0;
        ofu_data_t data1;
        ofu_tag_t  tag;
    } ofu_operand_t;

    // Snooped RAM write port
    typedef struct packed {
        logic      en;
        ofu_addr_t addr;
        ofu_data_t data;
    } ofu_snoop_t;

endpackage

// File: rtl/operand_fetch_unit_if.sv
// Fetch-stage bus bundle. Signal suffixes are from the fetch unit's point of view.
//   issue_*   : request handshake from issue
//   read_*    : RAM read addresses out, ram_data_* registered RAM data in
//   snoop_i   : copy of the RAM write port
//   operand_* : operand-pair handshake to execute
interface operand_fetch_unit_if;
    import operand_fetch_unit_pkg::*;

    logic         issue_valid_i;
    logic         issue_ready_o;
    ofu_req_t     issue_req_i;
    ofu_addr_t    read_addr0_o;
    ofu_addr_t    read_addr1_o;
    ofu_data_t    ram_data0_i;
    ofu_data_t    ram_data1_i;
    ofu_snoop_t   snoop_i;
    logic         operand_valid_o;
    logic         operand_ready_i;
    ofu_operand_t operand_o;

    modport slave (
        input  issue_valid_i, issue_req_i, ram_data0_i, ram_data1_i, snoop_i, operand_ready_i,
        output issue_ready_o, read_addr0_o, read_addr1_o, operand_valid_o, operand_o
    );

    modport master (
        output issue_valid_i, issue_req_i, ram_data0_i, ram_data1_i, snoop_i, operand_ready_i,
        input  issue_ready_o, read_addr0_o, read_addr1_o, operand_valid_o, operand_o
    );
endinterface

// File: rtl/operand_fetch_unit_entry.sv
// ofu_entry: one operand slot {addr0, addr1, data0, data1, tag, valid} with the
// two write-snoop comparators. An operand not yet "owned" falls back to
// fall_data*_i (the RAM output for the in-flight slot).
// Ports: clk, rst_n; load_i/clear_i slot control; req_i, load_data*_i,
// load_own*_i load payload; fall_data*_i fallback data; snoop_i write port;
// valid_o, op_o slot contents (merged view when COMB_OUT, else registered).
module ofu_entry
    import operand_fetch_unit_pkg::*;
#(
    parameter bit COMB_OUT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  ofu_req_t     req_i,
    input  ofu_data_t    load_data0_i,
    input  ofu_data_t    load_data1_i,
    input  logic         load_own0_i,
    input  logic         load_own1_i,
    input  ofu_data_t    fall_data0_i,
    input  ofu_data_t    fall_data1_i,
    input  ofu_snoop_t   snoop_i,
    output logic         valid_o,
    output ofu_operand_t op_o
);

    logic      valid_q, valid_d;
    ofu_req_t  req_q, req_d;
    ofu_data_t data0_q, data0_d, data1_q, data1_d;
    logic      own0_q, own0_d, own1_q, own1_d;
    logic      hit0_c, hit1_c;
    ofu_data_t merged0_c, merged1_c;

    // A write to a held address wins over stored or fallback data
    always_comb begin
        hit0_c    = valid_q && snoop_i.en && (snoop_i.addr == req_q.addr0);
        hit1_c    = valid_q && snoop_i.en && (snoop_i.addr == req_q.addr1);
        merged0_c = hit0_c ? snoop_i.data : (own0_q ? data0_q : fall_data0_i);
        merged1_c = hit1_c ? snoop_i.data : (own1_q ? data1_q : fall_data1_i);
    end

    // Next state: load has priority, clear zeroes the slot, otherwise track writes
    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        data0_d = data0_q;
        data1_d = data1_q;
        own0_d  = own0_q;
        own1_d  = own1_q;
        if (load_i) begin
            valid_d = 1'b1;
            req_d   = req_i;
            data0_d = load_data0_i;
            data1_d = load_data1_i;
            own0_d  = load_own0_i;
            own1_d  = load_own1_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
            req_d   = '0;
            data0_d = '0;
            data1_d = '0;
            own0_d  = 1'b0;
            own1_d  = 1'b0;
        end else if (valid_q) begin
            data0_d = merged0_c;
            data1_d = merged1_c;
            own0_d  = own0_q | hit0_c;
            own1_d  = own1_q | hit1_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            req_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
            own0_q  <= 1'b0;
            own1_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            own0_q  <= own0_d;
            own1_q  <= own1_d;
        end
    end

    always_comb begin
        valid_o  = valid_q;
        op_o.tag = req_q.tag;
        if (COMB_OUT) begin
            op_o.data0 = merged0_c;
            op_o.data1 = merged1_c;
        end else begin
            op_o.data0 = data0_q;
            op_o.data1 = data1_q;
        end
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: accepts issue requests, drives the RAM read addresses,
// merges RAM data with snooped writes and queues coherent operand pairs for
// execute in a DEPTH-entry circular FIFO.
// Ports: clk, rst_n (async, active low); bus (operand_fetch_unit_if.slave).
module operand_fetch_unit
    import operand_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_fetch_unit_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             issue_ready_q, issue_ready_d;
    ofu_addr_t        flight_addr0_q, flight_addr0_d, flight_addr1_q, flight_addr1_d;

    logic             accept_c, push_c, pop_c, own0_c, own1_c;
    logic             flight_valid;
    ofu_operand_t     flight_op;
    ofu_req_t         push_req_c;
    logic             ent_valid [DEPTH];
    ofu_operand_t     ent_op    [DEPTH];

    assign bus.read_addr0_o = bus.issue_req_i.addr0;
    assign bus.read_addr1_o = bus.issue_req_i.addr1;

    // Read-during-write returns old RAM data, so capture a same-cycle write here
    assign own0_c = bus.snoop_i.en && (bus.snoop_i.addr == bus.issue_req_i.addr0);
    assign own1_c = bus.snoop_i.en && (bus.snoop_i.addr == bus.issue_req_i.addr1);

    // In-flight slot: live for exactly the cycle the RAM data is returning
    ofu_entry #(.COMB_OUT(1'b1)) u_flight (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (accept_c),
        .clear_i      (1'b1),
        .req_i        (bus.issue_req_i),
        .load_data0_i (bus.snoop_i.data),
        .load_data1_i (bus.snoop_i.data),
        .load_own0_i  (own0_c),
        .load_own1_i  (own1_c),
        .fall_data0_i (bus.ram_data0_i),
        .fall_data1_i (bus.ram_data1_i),
        .snoop_i      (bus.snoop_i),
        .valid_o      (flight_valid),
        .op_o         (flight_op)
    );

    assign push_req_c = '{addr0: flight_addr0_q, addr1: flight_addr1_q, tag: flight_op.tag};

    // Buffer entries hold fully merged data, so they always own their operands
    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_entry
        ofu_entry #(.COMB_OUT(1'b0)) u_entry (
            .clk          (clk),
            .rst_n        (rst_n),
            .load_i       (push_c && (tail_q == PTR_W'(i))),
            .clear_i      (pop_c && (head_q == PTR_W'(i))),
            .req_i        (push_req_c),
            .load_data0_i (flight_op.data0),
            .load_data1_i (flight_op.data1),
            .load_own0_i  (1'b1),
            .load_own1_i  (1'b1),
            .fall_data0_i ('0),
            .fall_data1_i ('0),
            .snoop_i      (bus.snoop_i),
            .valid_o      (ent_valid[i]),
            .op_o         (ent_op[i])
        );
    end

    // Empty entries are zeroed, so the head mux yields 0 when the buffer is empty
    assign bus.operand_valid_o = ent_valid[head_q];
    assign bus.operand_o       = ent_op[head_q];
    assign bus.issue_ready_o   = issue_ready_q;

    // Pointer, occupancy and credit next-state
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        flight_addr0_d = flight_addr0_q;
        flight_addr1_d = flight_addr1_q;
        accept_c       = bus.issue_valid_i && issue_ready_q;
        push_c         = flight_valid;
        pop_c          = ent_valid[head_q] && bus.operand_ready_i;
        if (push_c) tail_d = tail_q + PTR_W'(1);
        if (pop_c)  head_d = head_q + PTR_W'(1);
        if (accept_c) begin
            flight_addr0_d = bus.issue_req_i.addr0;
            flight_addr1_d = bus.issue_req_i.addr1;
        end
        count_d       = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        // Credit computed into a register: no path from operand_ready_i to issue_ready_o
        issue_ready_d = (32'(accept_c) + 32'(count_d)) < DEPTH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            issue_ready_q  <= 1'b1;
            flight_addr0_q <= '0;
            flight_addr1_q <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            issue_ready_q  <= issue_ready_d;
            flight_addr0_q <= flight_addr0_d;
            flight_addr1_q <= flight_addr1_d;
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Self-checking bench for operand_fetch_unit with a 1-cycle registered dual-read RAM model.
module tb_operand_fetch_unit;
    import operand_fetch_unit_pkg::*;

    localparam int unsigned DEPTH  = 2;
    localparam int          NWORDS = 1 << DATA_ADDRESS_WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_fetch_unit_if bus();

    operand_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // RAM model: reset reloads A000_00xx, write-first-not, registered reads
    ofu_data_t mem [NWORDS];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        end else if (bus.snoop_i.en) begin
            mem[bus.snoop_i.addr] <= bus.snoop_i.data;
        end
        bus.ram_data0_i <= mem[bus.read_addr0_o];
        bus.ram_data1_i <= mem[bus.read_addr1_o];
    end

    ofu_tag_t pop_log [$];
    always @(negedge clk) begin
        if (bus.operand_valid_o && bus.operand_ready_i) pop_log.push_back(bus.operand_o.tag);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.issue_valid_i = 1'b0;
        bus.issue_req_i   = '0;
        bus.snoop_i       = '0;
    endtask

    // Present a request (optionally with a write) until accepted; returns one tick after acceptance
    task automatic issue(input ofu_addr_t a0, input ofu_addr_t a1, input ofu_tag_t tag,
                         input logic wen, input ofu_addr_t wa, input ofu_data_t wd);
        bit got = 1'b0;
        bus.issue_valid_i = 1'b1;
        bus.issue_req_i   = '{addr0: a0, addr1: a1, tag: tag};
        bus.snoop_i       = '{en: wen, addr: wa, data: wd};
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus.issue_ready_o) got = 1'b1;
            @(posedge clk);
            #1;
        end
        drive_idle();
        check("issue_accept_timeout", 80'(got), 80'(1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    ofu_req_t sb [$];

    // Scoreboard pop: head must equal the RAM contents as of this cycle
    task automatic pop_check();
        ofu_req_t e;
        if (bus.operand_valid_o && bus.operand_ready_i) begin
            if (sb.size() == 0) begin
                check("rand_pop_unexpected", 80'(1), 80'(0));
            end else begin
                e = sb.pop_front();
                check("rand_pop", 80'(bus.operand_o), 80'({mem[e.addr0], mem[e.addr1], e.tag}));
            end
        end
    endtask

    typedef struct {
        ofu_addr_t a0;
        ofu_addr_t a1;
        ofu_tag_t  tag;
        ofu_data_t e0;
        ofu_data_t e1;
    } vec_t;

    vec_t     vecs [4];
    ofu_tag_t rtag;

    initial begin
        vecs[0] = '{6'd3,  6'd5,  8'h11, 32'hA000_0003, 32'hA000_0005};
        vecs[1] = '{6'd0,  6'd63, 8'h22, 32'hA000_0000, 32'hA000_003F};
        vecs[2] = '{6'd9,  6'd9,  8'h33, 32'hA000_0009, 32'hA000_0009};
        vecs[3] = '{6'd42, 6'd17, 8'h44, 32'hA000_002A, 32'hA000_0011};

        rst_n = 1'b0;
        drive_idle();
        bus.operand_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 80'(bus.operand_valid_o), 80'(0));
        check("rst_data", 80'(bus.operand_o), 80'(0));
        check("rst_ready", 80'(bus.issue_ready_o), 80'(1));
        tick();
        rst_n = 1'b1;
        tick();

        // Single requests: latency T+2, data and tag echoed
        for (int v = 0; v < 4; v++) begin
            issue(vecs[v].a0, vecs[v].a1, vecs[v].tag, 1'b0, '0, '0);
            @(negedge clk);
            check("vec_valid_t1", 80'(bus.operand_valid_o), 80'(0));
            @(negedge clk);
            check("vec_valid_t2", 80'(bus.operand_valid_o), 80'(1));
            check("vec_data0", 80'(bus.operand_o.data0), 80'(vecs[v].e0));
            check("vec_data1", 80'(bus.operand_o.data1), 80'(vecs[v].e1));
            check("vec_tag", 80'(bus.operand_o.tag), 80'(vecs[v].tag));
            tick();
        end

        // Back-to-back issues pop on consecutive cycles
        bus.issue_valid_i = 1'b1;
        bus.issue_req_i   = '{addr0: 6'd1, addr1: 6'd2, tag: 8'h51};
        @(negedge clk);
        check("b2b_ready0", 80'(bus.issue_ready_o), 80'(1));
        tick();
        bus.issue_req_i = '{addr0: 6'd4, addr1: 6'd6, tag: 8'h52};
        @(negedge clk);
        check("b2b_ready1", 80'(bus.issue_ready_o), 80'(1));
        tick();
        drive_idle();
        @(negedge clk);
        check("b2b_pop0", 80'({bus.operand_valid_o, bus.operand_o.tag, bus.operand_o.data0}),
              80'({1'b1, 8'h51, 32'hA000_0001}));
        tick();
        @(negedge clk);
        check("b2b_pop1", 80'({bus.operand_valid_o, bus.operand_o.tag, bus.operand_o.data1}),
              80'({1'b1, 8'h52, 32'hA000_0006}));
        tick();
        @(negedge clk);
        check("b2b_empty", 80'(bus.operand_valid_o), 80'(0));
        tick();

        // Same-cycle write to a doubly-read address
        issue(6'd7, 6'd7, 8'h77, 1'b1, 6'd7, 32'hC0C0_C0C0);
        @(negedge clk);
        @(negedge clk);
        check("bypA_pair", 80'({bus.operand_valid_o, bus.operand_o.data0, bus.operand_o.data1}),
              80'({1'b1, 32'hC0C0_C0C0, 32'hC0C0_C0C0}));
        tick();
        tick();

        // Held head is updated by a later write; credit stops issue
        bus.operand_ready_i = 1'b0;
        pop_log.delete();
        issue(6'd1, 6'd2, 8'h31, 1'b0, '0, '0);
        issue(6'd3, 6'd4, 8'h32, 1'b0, '0, '0);
        bus.snoop_i = '{en: 1'b1, addr: 6'd1, data: 32'hD00D_0001};
        @(negedge clk);
        check("hold_ready", 80'(bus.issue_ready_o), 80'(0));
        check("hold_head_old", 80'({bus.operand_o.tag, bus.operand_o.data0}), 80'({8'h31, 32'hA000_0001}));
        tick();
        drive_idle();
        @(negedge clk);
        check("hold_head_new", 80'({bus.operand_o.tag, bus.operand_o.data0}), 80'({8'h31, 32'hD00D_0001}));
        tick();
        bus.operand_ready_i = 1'b1;
        @(negedge clk);
        check("hold_pop0", 80'(bus.operand_o.tag), 80'(8'h31));
        tick();
        @(negedge clk);
        check("hold_pop1", 80'({bus.operand_o.tag, bus.operand_o.data0, bus.operand_o.data1}),
              80'({8'h32, 32'hA000_0003, 32'hA000_0004}));
        repeat (3) tick();
        check("hold_log", 80'({32'(pop_log.size()), pop_log[0], pop_log[1]}), 80'({32'd2, 8'h31, 8'h32}));

        // Full buffer: pop and issue overlap without loss or duplication
        bus.operand_ready_i = 1'b0;
        pop_log.delete();
        issue(6'd10, 6'd11, 8'h41, 1'b0, '0, '0);
        issue(6'd12, 6'd13, 8'h42, 1'b0, '0, '0);
        tick();
        @(negedge clk);
        check("full_ready", 80'(bus.issue_ready_o), 80'(0));
        tick();
        bus.operand_ready_i = 1'b1;
        issue(6'd14, 6'd15, 8'h43, 1'b0, '0, '0);
        issue(6'd16, 6'd17, 8'h44, 1'b0, '0, '0);
        repeat (6) tick();
        check("full_log_size", 80'(pop_log.size()), 80'(4));
        for (int k = 0; k < 4 && k < pop_log.size(); k++) begin
            check("full_log_order", 80'(pop_log[k]), 80'(8'h41 + 8'(k)));
        end

        // Asynchronous reset mid-stream: one held, one in flight
        bus.operand_ready_i = 1'b0;
        pop_log.delete();
        issue(6'd20, 6'd21, 8'h5A, 1'b0, '0, '0);
        issue(6'd22, 6'd23, 8'h5B, 1'b0, '0, '0);
        @(negedge clk);
        check("mid_valid_pre", 80'(bus.operand_valid_o), 80'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out", 80'({bus.operand_valid_o, bus.issue_ready_o, bus.operand_o}),
              80'({1'b0, 1'b1, 72'd0}));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.operand_ready_i = 1'b1;
        issue(6'd24, 6'd25, 8'h5C, 1'b0, '0, '0);
        repeat (6) tick();
        check("mid_log", 80'({32'(pop_log.size()), pop_log[0]}), 80'({32'd1, 8'h5C}));

        // Random issue/write/ready against the RAM-content scoreboard
        rtag = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            bus.issue_valid_i   = ($urandom_range(3) != 0);
            bus.issue_req_i     = '{addr0: 6'($urandom_range(7)), addr1: 6'($urandom_range(7)), tag: rtag};
            bus.snoop_i         = '{en: 1'($urandom_range(1)), addr: 6'($urandom_range(7)), data: $urandom()};
            bus.operand_ready_i = ($urandom_range(3) != 0);
            @(negedge clk);
            pop_check();
            if (bus.issue_valid_i && bus.issue_ready_o) begin
                sb.push_back(bus.issue_req_i);
                rtag = rtag + 8'd1;
            end
            tick();
        end
        drive_idle();
        bus.operand_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            pop_check();
            tick();
        end
        check("rand_drained", 80'(sb.size()), 80'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
